// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and memory-side signals of the arbiter
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_address, mem_data_in, mem_we
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           mem_address, mem_data_in, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-ported memory between fetch and load/store ports
module mem_arbiter #(
  parameter int LATENCY         = 1,
  parameter bit RESET_PRIO_DATA = 1'b1
) (
  input  logic           clock,
  input  logic           reset,
  mem_arbiter_if.slave   bus,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t      state, next_state;
  logic [31:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
  logic        we_q, owner_q, last_grant, grant_i, grant_d, last_beat;
  logic [3:0]  cnt;
  // last_grant: 1 = data port was served last; the other port wins a tie
  assign grant_d   = state == IDLE && bus.d_req && (!bus.i_req || !last_grant);
  assign grant_i   = state == IDLE && bus.i_req && !grant_d;
  assign last_beat = cnt == 4'(LATENCY - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next_state;
  always_comb begin
    next_state = state;
    next_state = state == IDLE   ? ((grant_i || grant_d) ? ACCESS : IDLE) :
                 state == ACCESS ? (last_beat ? RESP : ACCESS) : IDLE;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      owner_q    <= 1'b0;
      last_grant <= !RESET_PRIO_DATA;
      cnt        <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else if (grant_i || grant_d) begin
      addr_q     <= grant_d ? bus.d_addr : bus.i_addr;
      wdata_q    <= grant_d ? bus.d_wdata : '0;
      we_q       <= grant_d && bus.d_we;
      owner_q    <= grant_d;
      last_grant <= grant_d;
      cnt        <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 4'd1;
      if (last_beat && owner_q)  d_rdata_q <= we_q ? '0 : bus.mem_data_out;
      if (last_beat && !owner_q) i_rdata_q <= bus.mem_data_out;
    end
  end
  always_comb begin
    busy            = state != IDLE;
    bus.i_ready     = grant_i;
    bus.d_ready     = grant_d;
    bus.i_rvalid    = state == RESP && !owner_q;
    bus.d_rvalid    = state == RESP && owner_q;
    bus.i_rdata     = i_rdata_q;
    bus.d_rdata     = d_rdata_q;
    bus.mem_address = busy ? addr_q : '0;
    bus.mem_data_in = state == ACCESS ? wdata_q : '0;
    bus.mem_we      = state == ACCESS && cnt == 4'd0 && we_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of two arbiter instances (LATENCY 1 and 3)
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic rst1, rst3, busy1, busy3;
  int   total = 0, bad = 0, wc1 = 0, dv3 = 0;
  int   n, ni, nd, bc, rv, edges, w0, d0;
  logic [3:0] seq;
  always #5 clock = ~clock;
  mem_arbiter_if b1 ();
  mem_arbiter_if b3 ();
  mem_arbiter #(.LATENCY(1), .RESET_PRIO_DATA(1'b1)) u1 (
    .clock(clock), .reset(rst1), .bus(b1.slave), .busy(busy1));
  mem_arbiter #(.LATENCY(3), .RESET_PRIO_DATA(1'b1)) u3 (
    .clock(clock), .reset(rst3), .bus(b3.slave), .busy(busy3));
  logic [31:0] m1 [0:63] = '{4: 32'hDEADBEEF, default: 32'h0};
  logic [31:0] m3 [0:63] = '{4: 32'hDEADBEEF, 8: 32'hCAFEF00D, default: 32'h0};
  assign b1.mem_data_out = m1[b1.mem_address[7:2]];
  assign b3.mem_data_out = m3[b3.mem_address[7:2]];
  always @(posedge clock) if (b1.mem_we) m1[b1.mem_address[7:2]] <= b1.mem_data_in;
  always @(posedge clock) if (b3.mem_we) m3[b3.mem_address[7:2]] <= b3.mem_data_in;
  always @(posedge clock) if (b1.mem_we) wc1 <= wc1 + 1;
  always @(posedge clock) if (b3.d_rvalid) dv3 <= dv3 + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    b1.i_req = 0; b1.i_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b3.i_req = 0; b3.i_addr = 0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
    #2;
    chk("rst_busy", {31'd0, busy1}, 0);
    chk("rst_outs", {27'd0, b1.i_ready, b1.d_ready, b1.i_rvalid, b1.d_rvalid, b1.mem_we}, 0);
    chk("rst_addr", b1.mem_address, 0);
    chk("rst_rdata", b3.i_rdata | b3.d_rdata, 0);
    tick();
    rst1 = 1'b0; rst3 = 1'b0;
    // fetch read, LATENCY=1
    b1.i_req = 1; b1.i_addr = 32'h10;
    #1;
    chk("f_iready", {31'd0, b1.i_ready}, 1);
    chk("f_dready", {31'd0, b1.d_ready}, 0);
    tick(); b1.i_req = 0;
    chk("f_addr", b1.mem_address, 32'h10);
    chk("f_rv_early", {31'd0, b1.i_rvalid}, 0);
    tick();
    chk("f_rvalid", {31'd0, b1.i_rvalid}, 1);
    chk("f_rdata", b1.i_rdata, 32'hDEADBEEF);
    tick();
    chk("f_rv_off", {31'd0, b1.i_rvalid}, 0);
    chk("f_idle", {31'd0, busy1}, 0);
    chk("f_hold", b1.i_rdata, 32'hDEADBEEF);
    chk("f_no_we", wc1, 0);
    // store then load
    w0 = wc1;
    b1.d_req = 1; b1.d_we = 1; b1.d_addr = 32'h20; b1.d_wdata = 32'h12345678;
    #1;
    chk("s_dready", {31'd0, b1.d_ready}, 1);
    tick(); b1.d_req = 0;
    chk("s_we", {31'd0, b1.mem_we}, 1);
    chk("s_wdata", b1.mem_data_in, 32'h12345678);
    chk("s_addr", b1.mem_address, 32'h20);
    tick();
    chk("s_ack", {31'd0, b1.d_rvalid}, 1);
    chk("s_rdata0", b1.d_rdata, 0);
    chk("s_we_resp", {31'd0, b1.mem_we}, 0);
    tick();
    chk("s_one_pulse", wc1 - w0, 1);
    b1.d_req = 1; b1.d_we = 0;
    #1;
    chk("l_dready", {31'd0, b1.d_ready}, 1);
    tick(); b1.d_req = 0;
    tick();
    chk("l_rvalid", {31'd0, b1.d_rvalid}, 1);
    chk("l_rdata", b1.d_rdata, 32'h12345678);
    tick();
    // simultaneous requests held from reset
    rst1 = 1'b1;
    b1.i_req = 1; b1.i_addr = 32'h10; b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h20;
    tick();
    rst1 = 1'b0;
    #1;
    seq = '0; n = 0; ni = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      chk("c_one_ready", {31'd0, b1.i_ready & b1.d_ready}, 0);
      chk("c_one_rvalid", {31'd0, b1.i_rvalid & b1.d_rvalid}, 0);
      if (b1.i_ready || b1.d_ready) begin
        if (n < 4) seq[n] = b1.d_ready;
        n++;
      end
      if (b1.i_rvalid) begin ni++; chk("c_irdata", b1.i_rdata, 32'hDEADBEEF); end
      if (b1.d_rvalid) begin nd++; chk("c_drdata", b1.d_rdata, 32'h12345678); end
      tick();
    end
    b1.i_req = 0; b1.d_req = 0;
    chk("c_order", {28'd0, seq}, 32'h5);
    chk("c_grants", n, 4);
    chk("c_i_resps", ni, 2);
    chk("c_d_resps", nd, 2);
    // LATENCY=3 fetch with competing requests during ACCESS
    b3.i_req = 1; b3.i_addr = 32'h10;
    #1;
    chk("l3_iready", {31'd0, b3.i_ready}, 1);
    tick();
    b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h20;
    bc = 0; rv = 0; edges = 1;
    while (busy3 && edges < 20) begin
      bc++;
      chk("l3_no_ready", {30'd0, b3.i_ready, b3.d_ready}, 0);
      if (b3.i_rvalid) rv = edges;
      tick();
      edges++;
    end
    chk("l3_busy_cycles", bc, 4);
    chk("l3_rv_edge", rv, 4);
    chk("l3_rdata", b3.i_rdata, 32'hDEADBEEF);
    chk("l3_d_wins", {30'd0, b3.i_ready, b3.d_ready}, 1);
    tick(); b3.d_req = 0;
    repeat (3) tick();
    chk("l3_drvalid", {31'd0, b3.d_rvalid}, 1);
    chk("l3_drdata", b3.d_rdata, 32'hCAFEF00D);
    tick();
    chk("l3_i_next", {30'd0, b3.i_ready, b3.d_ready}, 2);
    tick(); b3.i_req = 0;
    repeat (4) tick();
    // reset during a LATENCY=3 write
    d0 = dv3;
    b3.d_req = 1; b3.d_we = 1; b3.d_addr = 32'h30; b3.d_wdata = 32'hA5A5A5A5;
    #1;
    chk("r_dready", {31'd0, b3.d_ready}, 1);
    tick(); b3.d_req = 0; b3.d_we = 0;
    chk("r_we", {31'd0, b3.mem_we}, 1);
    tick();
    rst3 = 1'b1;
    #1;
    chk("r_busy", {31'd0, busy3}, 0);
    chk("r_outs", {28'd0, b3.mem_we, b3.d_rvalid, b3.i_ready, b3.d_ready}, 0);
    chk("r_addr", b3.mem_address, 0);
    chk("r_wdata", b3.mem_data_in, 0);
    repeat (3) tick();
    rst3 = 1'b0;
    tick();
    chk("r_no_rvalid", dv3 - d0, 0);
    b3.i_req = 1; b3.i_addr = 32'h10;
    #1;
    chk("r_iready", {31'd0, b3.i_ready}, 1);
    tick(); b3.i_req = 0;
    repeat (3) tick();
    chk("r_irvalid", {31'd0, b3.i_rvalid}, 1);
    chk("r_irdata", b3.i_rdata, 32'hDEADBEEF);
    tick();
    // idle
    for (int k = 0; k < 10; k++) begin
      chk("idle_ctl", {28'd0, busy1, b1.mem_we, b1.i_ready, b1.d_ready}, 0);
      chk("idle_addr", b1.mem_address, 0);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
